cov_bram_arbiter: RTL and testbench

Arbitrates the single port of the covariance-matrix BRAM between two requesters: the TPU writeback controller, which writes the 4-word covariance matrix, and the downstream eigen-solver reader, which reads it. Access is granted in atomic bursts, with round-robin fairness between the two requesters. The block also tracks whether a complete matrix is in the BRAM and blocks reads until one is. It sits between the TPU writeback path and the BRAM, and owns all BRAM control pins.

---
 rtl/pca_pkg.sv | 17 +
 rtl/cov_rd_valid_pipe.sv | 42 ++++
 rtl/cov_bram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cov_bram_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pca_pkg.sv
// pca_pkg
// Shared types and default sizes for the PCA covariance path.
//   arb_state_t : BRAM port arbiter states (idle, write burst, read burst)
//   COV_ADDR_W  : covariance BRAM address width (4 words)
//   COV_DATA_W  : covariance BRAM word width
package pca_pkg;

  localparam int COV_ADDR_W = 2;
  localparam int COV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cov_rd_valid_pipe.sv
// cov_rd_valid_pipe
// DEPTH-deep shift register that delays the read-beat strobe so that it
// lines up with data coming back from the BRAM.
// Ports:
//   clk       in  system clock
//   clr       in  synchronous clear, drops anything in flight
//   in_valid  in  read beat issued this cycle
//   out_valid out in_valid delayed by DEPTH cycles
module cov_rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_d[gi] = in_valid;
      end else begin : g_tail
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[DEPTH-1];

endmodule

// File: rtl/cov_bram_arbiter.sv
// cov_bram_arbiter
// Owns the single port of the covariance-matrix BRAM and shares it between
// the TPU writeback controller (writer) and the eigen-solver (reader) in
// atomic bursts with round-robin fairness. Reads are held off until a full
// matrix has been written; a completed read consumes the matrix.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   w_req/w_addr/w_data/w_last     writer burst interface, w_gnt grant
//   r_req/r_addr/r_last            reader burst interface, r_gnt grant
//   r_data/r_valid                 read return (r_data is douta)
//   ena/wea/addra/dina/douta       BRAM port
//   matrix_valid                   complete, unconsumed matrix present
//   burst_err                      sticky: burst overran without last
module cov_bram_arbiter
  import pca_pkg::*;
#(
  parameter int ADDR_W = COV_ADDR_W,
  parameter int DATA_W = COV_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_last,
  output logic              w_gnt,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              r_last,
  output logic              r_gnt,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              matrix_valid,
  output logic              burst_err
);

  localparam int MAX_BEATS = 2 ** ADDR_W;
  // Count value seen during the final permitted beat of a burst.
  localparam logic [ADDR_W:0] LIMIT_CNT = (ADDR_W + 1)'(MAX_BEATS - 1);

  arb_state_t        state_q, state_d;
  logic              last_rd_q, last_rd_d;   // 1: reader won the last grant
  logic [ADDR_W:0]   beat_cnt_q, beat_cnt_d;
  logic              matrix_valid_q, matrix_valid_d;
  logic              burst_err_q, burst_err_d;
  logic [DATA_W-1:0] dina_q, dina_d;

  logic w_beat;
  logic r_beat;
  logic w_elig;
  logic r_elig;
  logic at_limit;

  assign w_beat   = (state_q == WR_BURST) && w_req;
  assign r_beat   = (state_q == RD_BURST) && r_req;
  assign w_elig   = w_req;
  assign r_elig   = r_req && matrix_valid_q;
  assign at_limit = (beat_cnt_q == LIMIT_CNT);

  always_comb begin
    state_d        = state_q;
    last_rd_d      = last_rd_q;
    beat_cnt_d     = beat_cnt_q;
    matrix_valid_d = matrix_valid_q;
    burst_err_d    = burst_err_q;
    dina_d         = dina_q;

    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time goes next.
        if (w_elig && (!r_elig || last_rd_q)) begin
          state_d        = WR_BURST;
          last_rd_d      = 1'b0;
          // Contents are about to be overwritten, so the old matrix is stale.
          matrix_valid_d = 1'b0;
        end else if (r_elig) begin
          state_d   = RD_BURST;
          last_rd_d = 1'b1;
        end
      end
      WR_BURST: begin
        if (w_beat) begin
          dina_d = w_data;
          if (w_last) begin
            state_d        = IDLE;
            matrix_valid_d = 1'b1;
          end else if (at_limit) begin
            // Overrun: end the burst, leave the matrix marked incomplete.
            state_d     = IDLE;
            burst_err_d = 1'b1;
          end
        end
      end
      RD_BURST: begin
        if (r_beat) begin
          if (r_last) begin
            state_d        = IDLE;
            matrix_valid_d = 1'b0;
          end else if (at_limit) begin
            state_d     = IDLE;
            burst_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      beat_cnt_d = '0;
    end else if (w_beat || r_beat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_rd_q      <= 1'b1;
      beat_cnt_q     <= '0;
      matrix_valid_q <= 1'b0;
      burst_err_q    <= 1'b0;
      dina_q         <= '0;
    end else begin
      state_q        <= state_d;
      last_rd_q      <= last_rd_d;
      beat_cnt_q     <= beat_cnt_d;
      matrix_valid_q <= matrix_valid_d;
      burst_err_q    <= burst_err_d;
      dina_q         <= dina_d;
    end
  end

  cov_rd_valid_pipe #(
    .DEPTH(RD_LAT)
  ) u_rd_valid_pipe (
    .clk      (clk),
    .clr      (rst),
    .in_valid (r_beat),
    .out_valid(r_valid)
  );

  // BRAM pins follow the granted requester only during a beat; dina keeps
  // the last written word otherwise so the bus does not toggle on reads.
  assign ena   = w_beat || r_beat;
  assign wea   = w_beat;
  assign addra = w_beat ? w_addr : (r_beat ? r_addr : '0);
  assign dina  = w_beat ? w_data : dina_q;

  assign w_gnt        = (state_q == WR_BURST);
  assign r_gnt        = (state_q == RD_BURST);
  assign r_data       = douta;
  assign matrix_valid = matrix_valid_q;
  assign burst_err    = burst_err_q;

endmodule

// File: tb/tb_cov_bram_arbiter.sv
// tb_cov_bram_arbiter
// Directed bench for cov_bram_arbiter with a behavioural 1-cycle BRAM.
// Inputs are driven and outputs sampled just after the falling edge.
module tb_cov_bram_arbiter;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam logic [31:0] STEP = 32'h04040404;
  localparam logic [31:0] W1   = 32'h03020100;
  localparam logic [31:0] W2   = 32'hA0A1A2A3;
  localparam logic [31:0] W3   = 32'h55000011;

  logic              clk;
  logic              rst;
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_last;
  logic              w_gnt;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last;
  logic              r_gnt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;
  logic              matrix_valid;
  logic              burst_err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:3];

  cov_bram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_req       (w_req),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .w_last      (w_last),
    .w_gnt       (w_gnt),
    .r_req       (r_req),
    .r_addr      (r_addr),
    .r_last      (r_last),
    .r_gnt       (r_gnt),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .ena         (ena),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .douta       (douta),
    .matrix_valid(matrix_valid),
    .burst_err   (burst_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port BRAM, read latency 1.
  always @(posedge clk) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      else     douta <= mem[addra];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Entered at a falling edge with the arbiter idle; leaves at the falling
  // edge after the last beat, with w_req dropped.
  task automatic write4(input logic [31:0] base);
    w_req = 1'b1; w_addr = '0; w_last = 1'b0;
    #1 check_val("wr_req_no_gnt_yet", w_gnt, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_addr = ADDR_W'(i);
      w_data = base + 32'(i) * STEP;
      w_last = (i == 3);
      #1;
      check_val("wr_gnt", w_gnt, 1);
      check_val("wr_ena", ena, 1);
      check_val("wr_wea", wea, 1);
      check_val("wr_addra", addra, 32'(i));
      check_val("wr_dina", dina, base + 32'(i) * STEP);
      check_val("wr_mv_low", matrix_valid, 0);
    end
    @(negedge clk);
    w_req = 1'b0; w_last = 1'b0;
    #1;
    check_val("wr_end_gnt", w_gnt, 0);
    check_val("wr_end_mv", matrix_valid, 1);
    check_val("wr_end_ena", ena, 0);
  endtask

  // Entered at a falling edge where the reader is about to be granted.
  task automatic read4(input logic [31:0] base, input logic [31:0] last_word, input bit with_last);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r_addr = ADDR_W'(i);
      r_last = with_last && (i == 3);
      #1;
      check_val("rd_gnt", r_gnt, 1);
      check_val("rd_ena", ena, 1);
      check_val("rd_wea", wea, 0);
      check_val("rd_addra", addra, 32'(i));
      check_val("rd_dina_hold", dina, last_word);
      if (i == 0) begin
        check_val("rd_valid0", r_valid, 0);
      end else begin
        check_val("rd_valid", r_valid, 1);
        check_val("rd_data", r_data, base + 32'(i - 1) * STEP);
      end
    end
    @(negedge clk);
    r_last = 1'b0;
    #1;
    check_val("rd_end_gnt", r_gnt, 0);
    check_val("rd_end_valid", r_valid, 1);
    check_val("rd_end_data", r_data, base + 32'd3 * STEP);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    douta = '0;
    rst = 1'b1;
    w_req = 1'b0; w_addr = '0; w_data = '0; w_last = 1'b0;
    r_req = 1'b0; r_addr = '0; r_last = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_w_gnt", w_gnt, 0);
    check_val("rst_r_gnt", r_gnt, 0);
    check_val("rst_ena", ena, 0);
    check_val("rst_wea", wea, 0);
    check_val("rst_addra", addra, 0);
    check_val("rst_dina", dina, 0);
    check_val("rst_r_valid", r_valid, 0);
    check_val("rst_mv", matrix_valid, 0);
    check_val("rst_err", burst_err, 0);

    // Reader asks with no matrix present: ignored.
    @(negedge clk);
    rst = 1'b0; r_req = 1'b1;
    #1 check_val("rd_blocked0", r_gnt, 0);
    @(negedge clk);
    #1 check_val("rd_blocked1", r_gnt, 0);

    // Full write while the reader keeps waiting, then the reader gets in.
    write4(W1);
    read4(W1, W1 + 32'd3 * STEP, 1'b1);
    check_val("mv_consumed", matrix_valid, 0);
    r_req = 1'b0;

    // Second matrix, writer now last winner.
    @(negedge clk);
    write4(W2);

    // Tie: reader wins; read overruns without r_last.
    w_req = 1'b1; r_req = 1'b1;
    read4(W2, W2 + 32'd3 * STEP, 1'b0);
    check_val("rd_ovf_err", burst_err, 1);
    check_val("rd_ovf_mv_kept", matrix_valid, 1);

    // Tie again: writer's turn; write overruns with no w_last.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_addr = ADDR_W'(i);
      w_data = W3 + 32'(i);
      w_last = 1'b0;
      #1;
      check_val("tie_w_gnt", w_gnt, 1);
      check_val("tie_r_gnt", r_gnt, 0);
      check_val("ovf_wea", wea, 1);
    end
    @(negedge clk);
    #1;
    check_val("ovf_w_gnt_end", w_gnt, 0);
    check_val("ovf_ena_5th", ena, 0);
    check_val("ovf_err", burst_err, 1);
    check_val("ovf_mv", matrix_valid, 0);
    w_req = 1'b0; r_req = 1'b0;
    @(negedge clk);
    #1 check_val("err_sticky", burst_err, 1);

    // Reset in the middle of a read with one beat in flight.
    write4(W1);
    r_req = 1'b1; r_addr = '0;
    @(negedge clk);
    rst = 1'b1;
    #1 check_val("mid_rd_gnt", r_gnt, 1);
    @(negedge clk);
    #1;
    check_val("rst_mid_r_gnt", r_gnt, 0);
    check_val("rst_mid_r_valid", r_valid, 0);
    check_val("rst_mid_mv", matrix_valid, 0);
    check_val("rst_mid_err", burst_err, 0);
    rst = 1'b0; r_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
